// File: rtl/xulie_gen.sv
// xulie_gen: serial sequence generator.
// Captures a parallel pattern and a length, then shifts the pattern out
// MSB-first (bit len-1 down to bit 0) on Dout, one bit per clock. With Loop
// held high the captured frame repeats back-to-back with no gap cycle.
// Every output is driven straight from a flop.
module xulie_gen #(
   parameter int WIDTH = 8,
   parameter int LW    = $clog2(WIDTH + 1)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Stop,
   input  logic [WIDTH-1:0] Pattern,
   input  logic [LW-1:0]    Len,
   input  logic             Loop,
   output logic             Dout,
   output logic             Busy,
   output logic             Frame,
   output logic             Done
);

   // Bit-index width: enough to address every bit of the pattern.
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [0:0]       state_r, state_s;
   logic [CW-1:0]    cnt_r, cnt_s;        // index of the bit currently on Dout
   logic [CW-1:0]    len_r, len_s;        // index of the first bit (len-1)
   logic [WIDTH-1:0] shadow_r, shadow_s;
   logic             dout_r, dout_s;
   logic             busy_r, busy_s;
   logic             frame_r, frame_s;
   logic             done_r, done_s;

   logic [LW-1:0]    len_eff_s;
   logic [CW-1:0]    last_idx_s;
   logic [CW-1:0]    prev_idx_s;

   // Clamp the requested length to the pattern width and derive bit indices.
   always_comb begin
      if (Len > WIDTH_L) begin
         len_eff_s = WIDTH_L;
      end else begin
         len_eff_s = Len;
      end
      last_idx_s = CW'(len_eff_s - LW'(1'b1));
      prev_idx_s = cnt_r - CW'(1'b1);
   end

   // Next-state and next-output logic; outputs default to the idle value.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      len_s    = len_r;
      shadow_s = shadow_r;
      dout_s   = 1'b0;
      busy_s   = 1'b0;
      frame_s  = 1'b0;
      done_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (Stop) begin
               state_s = ST_IDLE;
            end else if (Start) begin
               shadow_s = Pattern;
               if (len_eff_s == {LW{1'b0}}) begin
                  // Empty frame: nothing to send, just report completion.
                  len_s  = {CW{1'b0}};
                  done_s = 1'b1;
               end else begin
                  len_s   = last_idx_s;
                  cnt_s   = last_idx_s;
                  state_s = ST_SHIFT;
                  dout_s  = Pattern[last_idx_s];
                  busy_s  = 1'b1;
                  frame_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (Stop) begin
               // Abort: drop straight to idle without a completion pulse.
               state_s = ST_IDLE;
               cnt_s   = {CW{1'b0}};
            end else if (cnt_r == {CW{1'b0}}) begin
               if (Loop) begin
                  // Restart from the captured copy; live inputs are ignored.
                  cnt_s   = len_r;
                  dout_s  = shadow_r[len_r];
                  busy_s  = 1'b1;
                  frame_s = 1'b1;
               end else begin
                  state_s = ST_IDLE;
                  done_s  = 1'b1;
               end
            end else begin
               cnt_s  = prev_idx_s;
               dout_s = shadow_r[prev_idx_s];
               busy_s = 1'b1;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = {CW{1'b0}};
         end
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r  <= ST_IDLE;
         cnt_r    <= {CW{1'b0}};
         len_r    <= {CW{1'b0}};
         shadow_r <= {WIDTH{1'b0}};
         dout_r   <= 1'b0;
         busy_r   <= 1'b0;
         frame_r  <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         len_r    <= len_s;
         shadow_r <= shadow_s;
         dout_r   <= dout_s;
         busy_r   <= busy_s;
         frame_r  <= frame_s;
         done_r   <= done_s;
      end
   end

   assign Dout  = dout_r;
   assign Busy  = busy_r;
   assign Frame = frame_r;
   assign Done  = done_r;

endmodule

// File: tb/tb_xulie_gen.sv
// Testbench for xulie_gen: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_xulie_gen;

   localparam int WIDTH = 8;
   localparam int LW    = $clog2(WIDTH + 1);

   logic             Clk = 1'b0;
   logic             Reset = 1'b1;
   logic             Start = 1'b0;
   logic             Stop = 1'b0;
   logic [WIDTH-1:0] Pattern = '0;
   logic [LW-1:0]    Len = '0;
   logic             Loop = 1'b0;
   logic             Dout, Busy, Frame, Done;

   int checks = 0;
   int errors = 0;

   // Model: queue of bits still to appear on Dout (front = current bit).
   bit m_q[$];
   bit m_frame[$];
   int m_flen = 0;
   bit m_done = 1'b0;
   bit en = 1'b0;

   xulie_gen #(.WIDTH(WIDTH), .LW(LW)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop),
      .Pattern(Pattern), .Len(Len), .Loop(Loop),
      .Dout(Dout), .Busy(Busy), .Frame(Frame), .Done(Done)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model on each edge, then compare DUT outputs 1 time unit later.
   always @(posedge Clk) begin
      int l;
      m_done = 1'b0;
      if (Reset) begin
         m_q.delete();
      end else if (m_q.size() != 0) begin
         if (Stop) begin
            m_q.delete();
         end else begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
               if (Loop) m_q = m_frame;
               else      m_done = 1'b1;
            end
         end
      end else if (Start && !Stop) begin
         l = (int'(Len) > WIDTH) ? WIDTH : int'(Len);
         m_frame.delete();
         for (int i = l - 1; i >= 0; i--) m_frame.push_back(Pattern[i]);
         m_flen = l;
         if (l == 0) m_done = 1'b1;
         else        m_q = m_frame;
      end
      #1;
      if (en) begin
         chk("model_dout",  {31'd0, Dout},  {31'd0, (m_q.size() != 0) ? m_q[0] : 1'b0});
         chk("model_busy",  {31'd0, Busy},  {31'd0, m_q.size() != 0});
         chk("model_frame", {31'd0, Frame}, {31'd0, (m_q.size() != 0) && (m_q.size() == m_flen)});
         chk("model_done",  {31'd0, Done},  {31'd0, m_done});
      end
   end

   task automatic start_frame(input logic [7:0] pat, input logic [LW-1:0] len, input logic lp);
      Pattern = pat;
      Len     = len;
      Loop    = lp;
      Start   = 1'b1;
      @(negedge Clk);
      Start   = 1'b0;
   endtask

   // Record n consecutive Dout/Frame values, oldest in the MSB position.
   task automatic collect(input int n, output logic [31:0] bits, output logic [31:0] frames);
      bits   = '0;
      frames = '0;
      for (int i = 0; i < n; i++) begin
         bits   = {bits[30:0], Dout};
         frames = {frames[30:0], Frame};
         @(negedge Clk);
      end
   endtask

   initial begin
      logic [31:0] b1, b2, b3, f1, f2, f3;

      // Reset state
      repeat (2) @(negedge Clk);
      chk("reset_outs", {28'd0, Dout, Busy, Frame, Done}, 32'd0);
      Reset = 1'b0;
      en    = 1'b1;
      @(negedge Clk);

      // Single 1110
      start_frame(8'h0E, 4'd4, 1'b0);
      collect(4, b1, f1);
      chk("single_bits",  b1, 32'b1110);
      chk("single_frame", f1, 32'b1000);
      chk("single_done",  {30'd0, Done, Busy}, 32'b10);
      @(negedge Clk);
      chk("single_done_clr", {31'd0, Done}, 32'd0);

      // Loop, with a Pattern change mid-loop and Loop dropped in the 3rd frame
      start_frame(8'h0E, 4'd4, 1'b1);
      collect(6, b1, f1);
      Pattern = 8'hFF;
      collect(3, b2, f2);
      Loop = 1'b0;
      collect(3, b3, f3);
      chk("loop_bits",  {b1[5:0], b2[2:0], b3[2:0]}, 32'b111011101110);
      chk("loop_frame", {f1[5:0], f2[2:0], f3[2:0]}, 32'b100010001000);
      chk("loop_done",  {30'd0, Done, Busy}, 32'b10);
      @(negedge Clk);

      // Len = 0
      start_frame(8'hFF, 4'd0, 1'b0);
      chk("len0_done", {29'd0, Done, Busy, Frame}, 32'b100);
      @(negedge Clk);
      chk("len0_clr", {31'd0, Done}, 32'd0);

      // Len = 15 clamps to 8
      start_frame(8'hA5, 4'd15, 1'b0);
      collect(8, b1, f1);
      chk("len15_bits", b1, 32'b10100101);
      chk("len15_done", {30'd0, Done, Busy}, 32'b10);
      @(negedge Clk);

      // Start during SHIFT is ignored
      start_frame(8'hC3, 4'd8, 1'b0);
      collect(2, b1, f1);
      Pattern = 8'h00;
      Len     = 4'd2;
      Start   = 1'b1;
      collect(1, b2, f2);
      Start   = 1'b0;
      collect(5, b3, f3);
      chk("busy_start_bits", {b1[1:0], b2[0], b3[4:0]}, 32'b11000011);
      chk("busy_start_done", {31'd0, Done}, 32'd1);
      @(negedge Clk);

      // Stop at bit 2 of an 8-bit frame
      start_frame(8'hFF, 4'd8, 1'b0);
      collect(2, b1, f1);
      Stop = 1'b1;
      @(negedge Clk);
      Stop = 1'b0;
      chk("stop_outs", {28'd0, Dout, Busy, Frame, Done}, 32'd0);
      @(negedge Clk);
      chk("stop_nodone", {31'd0, Done}, 32'd0);

      // Start and Stop together in IDLE
      Start = 1'b1;
      Stop  = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      Stop  = 1'b0;
      chk("startstop_idle", {30'd0, Busy, Done}, 32'd0);

      // Back-to-back: Start in the Done cycle
      start_frame(8'h0E, 4'd4, 1'b0);
      collect(4, b1, f1);
      chk("b2b_done", {31'd0, Done}, 32'd1);
      start_frame(8'h03, 4'd2, 1'b0);
      collect(2, b2, f2);
      chk("b2b_bits",  b2, 32'b11);
      chk("b2b_frame", f2, 32'b10);
      chk("b2b_done2", {31'd0, Done}, 32'd1);
      @(negedge Clk);

      // Asynchronous reset mid-frame
      start_frame(8'hFF, 4'd8, 1'b0);
      collect(3, b1, f1);
      #2 Reset = 1'b1;
      #1 chk("async_reset", {28'd0, Dout, Busy, Frame, Done}, 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      repeat (3) begin
         @(negedge Clk);
         chk("post_reset_idle", {31'd0, Busy}, 32'd0);
      end

      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         Start   = ($urandom_range(0, 3) == 0);
         Stop    = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 7) == 0) Loop = ~Loop;
         Pattern = 8'($urandom);
         Len     = 4'($urandom_range(0, 15));
         Reset   = ($urandom_range(0, 99) == 0);
         @(negedge Clk);
      end
      Reset = 1'b0;
      Start = 1'b0;
      Stop  = 1'b0;
      Loop  = 1'b0;
      repeat (12) @(negedge Clk);

      en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
